// File: rtl/reorder_buffer_mw.sv
// rtl/reorder_buffer_mw.sv - multi-width reorder buffer with in-order retire and fault squash
module reorder_buffer_mw #(
    parameter int NUM_ENTS = 64,
    parameter int DISP_W   = 2,
    parameter int RET_W    = 4,
    parameter int CMPL_W   = 4,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 7,
    localparam int IDX_W   = $clog2(NUM_ENTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DISP_W-1:0]          alloc_valid,
    input  logic [DISP_W*AREG_W-1:0]   alloc_dst_areg,
    input  logic [DISP_W*PREG_W-1:0]   alloc_dst_preg,
    input  logic [DISP_W*32-1:0]       alloc_pc,
    output logic                       alloc_ready,
    output logic [DISP_W*IDX_W-1:0]    alloc_idx,
    input  logic [CMPL_W-1:0]          cmpl_valid,
    input  logic [CMPL_W*IDX_W-1:0]    cmpl_idx,
    input  logic [CMPL_W-1:0]          cmpl_exc,
    input  logic [CMPL_W-1:0]          cmpl_mispred,
    output logic [RET_W-1:0]           ret_valid,
    output logic [RET_W*AREG_W-1:0]    ret_dst_areg,
    output logic [RET_W*PREG_W-1:0]    ret_dst_preg,
    output logic [RET_W-1:0]           ret_fault,
    output logic                       flush,
    output logic [31:0]                flush_pc,
    output logic                       flush_is_exc
);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_ENTS-1:0] valid_q, valid_d, done_q, done_d;
    logic [NUM_ENTS-1:0] exc_q, exc_d, mispred_q, mispred_d;
    logic [AREG_W-1:0]   areg_q [NUM_ENTS];
    logic [PREG_W-1:0]   preg_q [NUM_ENTS];
    logic [31:0]         pc_q   [NUM_ENTS];
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                flush_q;
    logic [31:0]         flush_pc_q;
    logic                flush_is_exc_q;

    logic [CNT_W-1:0]    n_ret, n_alloc, free_ents;
    logic                fault_retire, fault_exc, chain, lead;
    logic [31:0]         fault_pc;
    logic [IDX_W-1:0]    ridx, aidx, cidx;
    logic [DISP_W-1:0]   alloc_take;

    // Retire selection: contiguous done entries from head, stopping after the first fault
    always_comb begin
        ret_valid    = '0;
        ret_fault    = '0;
        ret_dst_areg = '0;
        ret_dst_preg = '0;
        n_ret        = '0;
        fault_retire = 1'b0;
        fault_exc    = 1'b0;
        fault_pc     = '0;
        chain        = 1'b1;
        ridx         = '0;
        for (int k = 0; k < RET_W; k++) begin
            ridx = head_q + IDX_W'(k);
            ret_dst_areg[k*AREG_W +: AREG_W] = areg_q[ridx];
            ret_dst_preg[k*PREG_W +: PREG_W] = preg_q[ridx];
            if (chain && valid_q[ridx] && done_q[ridx]) begin
                ret_valid[k] = 1'b1;
                n_ret        = n_ret + CNT_W'(1);
                if (exc_q[ridx] || mispred_q[ridx]) begin
                    ret_fault[k] = 1'b1;
                    fault_retire = 1'b1;
                    fault_pc     = pc_q[ridx];
                    fault_exc    = exc_q[ridx];
                    chain        = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        free_ents   = CNT_W'(NUM_ENTS) - count_q;
        alloc_ready = !rst && (free_ents >= CNT_W'(DISP_W)) && !fault_retire;
        alloc_take  = '0;
        alloc_idx   = '0;
        n_alloc     = '0;
        lead        = 1'b1;
        for (int i = 0; i < DISP_W; i++) begin
            lead          = lead & alloc_valid[i];
            alloc_take[i] = lead & alloc_ready;
            if (alloc_take[i]) n_alloc = n_alloc + CNT_W'(1);
            alloc_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
        end
    end

    // Entry flag update order: completion (only on entries valid at cycle start), retire, alloc
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        exc_d     = exc_q;
        mispred_d = mispred_q;
        cidx      = '0;
        aidx      = '0;
        for (int p = 0; p < CMPL_W; p++) begin
            cidx = cmpl_idx[p*IDX_W +: IDX_W];
            if (cmpl_valid[p] && valid_q[cidx]) begin
                done_d[cidx]    = 1'b1;
                exc_d[cidx]     = exc_d[cidx] | cmpl_exc[p];
                mispred_d[cidx] = mispred_d[cidx] | cmpl_mispred[p];
            end
        end
        for (int k = 0; k < RET_W; k++) begin
            if (ret_valid[k]) begin
                valid_d[head_q + IDX_W'(k)] = 1'b0;
                done_d[head_q + IDX_W'(k)]  = 1'b0;
            end
        end
        for (int i = 0; i < DISP_W; i++) begin
            aidx = tail_q + IDX_W'(i);
            if (alloc_take[i]) begin
                valid_d[aidx]   = 1'b1;
                done_d[aidx]    = 1'b0;
                exc_d[aidx]     = 1'b0;
                mispred_d[aidx] = 1'b0;
            end
        end
        head_d  = head_q + IDX_W'(n_ret);
        tail_d  = tail_q + IDX_W'(n_alloc);
        count_d = count_q + n_alloc - n_ret;
        if (fault_retire) begin
            valid_d   = '0;
            done_d    = '0;
            exc_d     = '0;
            mispred_d = '0;
            tail_d    = head_d;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            done_q         <= '0;
            exc_q          <= '0;
            mispred_q      <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            flush_is_exc_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            exc_q     <= exc_d;
            mispred_q <= mispred_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            flush_q   <= fault_retire;
            if (fault_retire) begin
                flush_pc_q     <= fault_pc;
                flush_is_exc_q <= fault_exc;
            end
        end
    end

    // Payload is only meaningful while the entry's valid bit is set, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_W; i++) begin
            if (alloc_take[i]) begin
                areg_q[tail_q + IDX_W'(i)] <= alloc_dst_areg[i*AREG_W +: AREG_W];
                preg_q[tail_q + IDX_W'(i)] <= alloc_dst_preg[i*PREG_W +: PREG_W];
                pc_q[tail_q + IDX_W'(i)]   <= alloc_pc[i*32 +: 32];
            end
        end
    end

    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;
    assign flush_is_exc = flush_is_exc_q;

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// tb/tb_reorder_buffer_mw.sv - scoreboard bench for reorder_buffer_mw
module tb_reorder_buffer_mw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  alloc_valid = '0;
    logic [9:0]  alloc_dst_areg = '0;
    logic [13:0] alloc_dst_preg = '0;
    logic [63:0] alloc_pc = '0;
    logic        alloc_ready;
    logic [11:0] alloc_idx;
    logic [3:0]  cmpl_valid = '0;
    logic [23:0] cmpl_idx = '0;
    logic [3:0]  cmpl_exc = '0;
    logic [3:0]  cmpl_mispred = '0;
    logic [3:0]  ret_valid;
    logic [19:0] ret_dst_areg;
    logic [27:0] ret_dst_preg;
    logic [3:0]  ret_fault;
    logic        flush;
    logic [31:0] flush_pc;
    logic        flush_is_exc;

    reorder_buffer_mw dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_dst_areg(alloc_dst_areg),
        .alloc_dst_preg(alloc_dst_preg), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .cmpl_exc(cmpl_exc), .cmpl_mispred(cmpl_mispred),
        .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg),
        .ret_dst_preg(ret_dst_preg), .ret_fault(ret_fault),
        .flush(flush), .flush_pc(flush_pc), .flush_is_exc(flush_is_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] areg;
        logic [6:0] preg;
        logic       fault;
    } ret_t;

    ret_t        exp_q[$];
    logic [32:0] flush_q[$];
    logic [4:0]  e_areg [64];
    logic [6:0]  e_preg [64];
    int          checks = 0;
    int          errors = 0;
    ret_t        mon_e;
    logic [32:0] mon_f;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] tag_areg(input int t);
        logic [31:0] v;
        v = t;
        return v[4:0];
    endfunction

    function automatic logic [6:0] tag_preg(input int t);
        logic [31:0] v;
        v = t;
        return v[6:0] ^ 7'h2a;
    endfunction

    task automatic push_ret(input int idx, input logic fault);
        ret_t r;
        r.areg  = e_areg[idx];
        r.preg  = e_preg[idx];
        r.fault = fault;
        exp_q.push_back(r);
    endtask

    // Drives n lanes with tags tag0.., checks ready/index, records payload, spends one cycle
    task automatic do_alloc(input int n, input int tag0, input logic exp_ready, input int idx0);
        for (int i = 0; i < 2; i++) begin
            alloc_valid[i]           = (i < n);
            alloc_dst_areg[i*5 +: 5] = tag_areg(tag0 + i);
            alloc_dst_preg[i*7 +: 7] = tag_preg(tag0 + i);
            alloc_pc[i*32 +: 32]     = (tag0 + i) << 8;
        end
        #1;
        chk("alloc_ready", alloc_ready, exp_ready);
        chk("alloc_idx0", alloc_idx[5:0], (idx0) % 64);
        chk("alloc_idx1", alloc_idx[11:6], (idx0 + 1) % 64);
        if (exp_ready) begin
            for (int i = 0; i < n; i++) begin
                e_areg[(idx0 + i) % 64] = tag_areg(tag0 + i);
                e_preg[(idx0 + i) % 64] = tag_preg(tag0 + i);
            end
        end
        @(posedge clk);
        #1;
        alloc_valid = '0;
    endtask

    task automatic cmpl4(input int i0, input int i1, input int i2, input int i3,
                         input logic [3:0] exc, input logic [3:0] mis);
        int ids[4];
        ids[0] = i0; ids[1] = i1; ids[2] = i2; ids[3] = i3;
        for (int p = 0; p < 4; p++) begin
            cmpl_valid[p]        = (ids[p] >= 0);
            cmpl_idx[p*6 +: 6]   = (ids[p] >= 0) ? 6'(ids[p]) : 6'd0;
        end
        cmpl_exc     = exc;
        cmpl_mispred = mis;
        @(posedge clk);
        #1;
        cmpl_valid   = '0;
        cmpl_exc     = '0;
        cmpl_mispred = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (ret_valid[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("retire_unexpected", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("retire_payload",
                            {ret_dst_areg[k*5 +: 5], ret_dst_preg[k*7 +: 7], ret_fault[k]},
                            {mon_e.areg, mon_e.preg, mon_e.fault});
                    end
                end
            end
            if (flush) begin
                if (flush_q.size() == 0) begin
                    chk("flush_unexpected", 1, 0);
                end else begin
                    mon_f = flush_q.pop_front();
                    chk("flush_info", {flush_is_exc, flush_pc}, mon_f);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        // 1: reset, then fill the ROB two lanes per cycle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_ready", alloc_ready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_flush", {flush, flush_pc, flush_is_exc}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", alloc_ready, 1);
        for (int c = 0; c < 32; c++) do_alloc(2, 2 * c, 1'b1, 2 * c);
        chk("full_ready", alloc_ready, 0);
        chk("full_idx0", alloc_idx[5:0], 0);

        // 2: complete 0..3 on a full ROB; alloc held off for that cycle
        for (int i = 0; i < 4; i++) push_ret(i, 1'b0);
        cmpl4(0, 1, 2, 3, 4'b0000, 4'b0000);
        chk("t2_ret_valid", ret_valid, 4'b1111);
        alloc_valid = 2'b11;
        #1;
        chk("t2_ready_full", alloc_ready, 0);
        @(posedge clk);
        #1;
        alloc_valid = '0;
        do_alloc(2, 64, 1'b1, 0);

        // 3: out-of-order completion holds retirement until the head is done
        cmpl4(6, -1, -1, -1, 4'b0000, 4'b0000);
        chk("t3_no_ret", ret_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 4; i < 7; i++) push_ret(i, 1'b0);
        cmpl4(4, 5, -1, -1, 4'b0000, 4'b0000);
        chk("t3_ret_valid", ret_valid, 4'b0111);
        @(posedge clk);
        #1;

        // 6: asynchronous reset with 10 live entries and a pending exception completion
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) do_alloc(2, 100 + 2 * c, 1'b1, 2 * c);
        cmpl_valid = 4'b0001;
        cmpl_idx   = '0;
        cmpl_exc   = 4'b0001;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ret_valid", ret_valid, 0);
        chk("t6_ready", alloc_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        cmpl_valid = '0;
        cmpl_exc   = '0;
        rst        = 1'b0;
        #1;
        chk("t6_ready_after", alloc_ready, 1);
        chk("t6_tail", alloc_idx[5:0], 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("t6_no_flush", {flush, ret_valid}, 0);
        end

        // 4: mispredict on entry 1 retires last, squashes 2..5, flushes with its PC
        for (int c = 0; c < 3; c++) do_alloc(2, 2 * c, 1'b1, 2 * c);
        cmpl4(2, 3, 4, 5, 4'b0000, 4'b0000);
        chk("t4_hold", ret_valid, 0);
        push_ret(0, 1'b0);
        push_ret(1, 1'b1);
        flush_q.push_back({1'b0, 32'h100});
        cmpl4(0, 1, -1, -1, 4'b0000, 4'b0010);
        chk("t4_ret_valid", ret_valid, 4'b0011);
        chk("t4_ret_fault", ret_fault, 4'b0010);
        chk("t4_ready_fault", alloc_ready, 0);
        @(posedge clk);
        #1;
        chk("t4_flush", {flush, flush_is_exc, flush_pc}, {2'b10, 32'h100});
        chk("t4_ready_flush", alloc_ready, 1);
        chk("t4_tail", alloc_idx[5:0], 2);
        @(posedge clk);
        #1;
        chk("t4_flush_end", flush, 0);
        repeat (2) @(posedge clk);
        #1;

        // 5: walk head to 62, then retire 62,63,0,1 in one cycle across the wrap
        for (int c = 0; c < 30; c++) do_alloc(2, 200 + 2 * c, 1'b1, 2 + 2 * c);
        for (int g = 0; g < 15; g++) begin
            for (int i = 0; i < 4; i++) push_ret(2 + 4 * g + i, 1'b0);
            cmpl4(2 + 4 * g, 3 + 4 * g, 4 + 4 * g, 5 + 4 * g, 4'b0000, 4'b0000);
        end
        repeat (2) @(posedge clk);
        #1;
        do_alloc(2, 300, 1'b1, 62);
        do_alloc(2, 302, 1'b1, 0);
        push_ret(62, 1'b0);
        push_ret(63, 1'b0);
        push_ret(0, 1'b0);
        push_ret(1, 1'b0);
        cmpl4(62, 63, 0, 1, 4'b0000, 4'b0000);
        chk("t5_ret_valid", ret_valid, 4'b1111);
        @(posedge clk);
        #1;
        chk("t5_ret_after", ret_valid, 0);
        chk("t5_tail", alloc_idx[5:0], 2);
        chk("t5_ready", alloc_ready, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("ret_queue_drained", exp_q.size(), 0);
        chk("flush_queue_drained", flush_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
